// File: rtl/id_stage.sv
// RV32I decode stage: instruction decode, register file read addressing,
// WB->ID bypass, load-use hazard detection and the ID/EX pipeline register.
module id_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    input  logic        flush_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        wb_wren_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        stall_o,
    output logic        ex_valid_o,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_imm_o,
    output logic [31:0] ex_rs1_data_o,
    output logic [31:0] ex_rs2_data_o,
    output logic [4:0]  ex_rs1_addr_o,
    output logic [4:0]  ex_rs2_addr_o,
    output logic [4:0]  ex_rd_addr_o,
    output logic [3:0]  ex_alu_op_o,
    output logic        ex_alu_a_pc_o,
    output logic        ex_alu_b_imm_o,
    output logic [2:0]  ex_funct3_o,
    output logic        ex_mem_rd_o,
    output logic        ex_mem_wr_o,
    output logic        ex_rd_wren_o,
    output logic [1:0]  ex_wb_sel_o,
    output logic        ex_branch_o,
    output logic        ex_jal_o,
    output logic        ex_jalr_o,
    output logic        ex_illegal_o
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode     = if_instr_i[6:0];
    assign rd         = if_instr_i[11:7];
    assign funct3     = if_instr_i[14:12];
    assign funct7     = if_instr_i[31:25];
    assign rs1_addr_o = if_instr_i[19:15];
    assign rs2_addr_o = if_instr_i[24:20];

    assign imm_i = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
    assign imm_s = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
    assign imm_b = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                    if_instr_i[30:25], if_instr_i[11:8], 1'b0};
    assign imm_u = {if_instr_i[31:12], 12'b0};
    assign imm_j = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                    if_instr_i[20], if_instr_i[30:21], 1'b0};

    logic [31:0] d_imm;
    alu_op_e     d_alu_op;
    logic        d_a_pc, d_b_imm, d_mem_rd, d_mem_wr, d_wr_rd;
    logic [1:0]  d_wb_sel;
    logic        d_branch, d_jal, d_jalr, d_illegal;
    logic        rs1_used, rs2_used;
    logic        d_rd_wren, d_mem_rd_q, d_mem_wr_q;

    // Decode the IF/ID instruction into EX controls and its immediate
    always_comb begin
        d_imm     = 32'd0;
        d_alu_op  = ALU_ADD;
        d_a_pc    = 1'b0;
        d_b_imm   = 1'b0;
        d_mem_rd  = 1'b0;
        d_mem_wr  = 1'b0;
        d_wr_rd   = 1'b0;
        d_wb_sel  = 2'd0;
        d_branch  = 1'b0;
        d_jal     = 1'b0;
        d_jalr    = 1'b0;
        d_illegal = 1'b0;
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                rs1_used = 1'b0;
                d_imm    = imm_u;
                d_alu_op = ALU_PASSB;
                d_b_imm  = 1'b1;
                d_wr_rd  = 1'b1;
            end
            OPC_AUIPC: begin
                rs1_used = 1'b0;
                d_imm    = imm_u;
                d_a_pc   = 1'b1;
                d_b_imm  = 1'b1;
                d_wr_rd  = 1'b1;
            end
            OPC_JAL: begin
                rs1_used = 1'b0;
                d_imm    = imm_j;
                d_a_pc   = 1'b1;
                d_b_imm  = 1'b1;
                d_wr_rd  = 1'b1;
                d_wb_sel = 2'd2;
                d_jal    = 1'b1;
            end
            OPC_JALR: begin
                d_imm     = imm_i;
                d_b_imm   = 1'b1;
                d_wr_rd   = 1'b1;
                d_wb_sel  = 2'd2;
                d_jalr    = 1'b1;
                d_illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                rs2_used  = 1'b1;
                d_imm     = imm_b;
                d_alu_op  = ALU_SUB;
                d_branch  = 1'b1;
                d_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                d_imm     = imm_i;
                d_b_imm   = 1'b1;
                d_mem_rd  = 1'b1;
                d_wr_rd   = 1'b1;
                d_wb_sel  = 2'd1;
                d_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                rs2_used  = 1'b1;
                d_imm     = imm_s;
                d_b_imm   = 1'b1;
                d_mem_wr  = 1'b1;
                d_illegal = (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                d_imm   = imm_i;
                d_b_imm = 1'b1;
                d_wr_rd = 1'b1;
                case (funct3)
                    3'b000: d_alu_op = ALU_ADD;
                    3'b001: begin
                        d_alu_op  = ALU_SLL;
                        d_illegal = (funct7 != 7'b0000000);
                    end
                    3'b010: d_alu_op = ALU_SLT;
                    3'b011: d_alu_op = ALU_SLTU;
                    3'b100: d_alu_op = ALU_XOR;
                    3'b101: begin
                        d_alu_op  = funct7[5] ? ALU_SRA : ALU_SRL;
                        d_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                    3'b110: d_alu_op = ALU_OR;
                    default: d_alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                rs2_used = 1'b1;
                d_wr_rd  = 1'b1;
                case (funct3)
                    3'b000: d_alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001: d_alu_op = ALU_SLL;
                    3'b010: d_alu_op = ALU_SLT;
                    3'b011: d_alu_op = ALU_SLTU;
                    3'b100: d_alu_op = ALU_XOR;
                    3'b101: d_alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: d_alu_op = ALU_OR;
                    default: d_alu_op = ALU_AND;
                endcase
                // 0100000 is only meaningful for SUB and SRA
                if (funct7 == 7'b0100000)
                    d_illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                else
                    d_illegal = (funct7 != 7'b0000000);
            end
            OPC_FENCE: begin
                d_illegal = (funct3 != 3'b000);
            end
            OPC_SYSTEM: begin
                // Only ECALL and EBREAK; no CSR support
                d_illegal = (if_instr_i != 32'h0000_0073) && (if_instr_i != 32'h0010_0073);
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
    end

    assign d_rd_wren  = d_wr_rd && !d_illegal && (rd != 5'd0);
    assign d_mem_rd_q = d_mem_rd && !d_illegal;
    assign d_mem_wr_q = d_mem_wr && !d_illegal;

    logic [31:0] op1, op2;
    logic        hz;

    // WB->ID bypass and load-use hazard detection
    always_comb begin
        op1 = rs1_data_i;
        op2 = rs2_data_i;
        if (wb_wren_i && (wb_addr_i != 5'd0) && (wb_addr_i == rs1_addr_o))
            op1 = wb_data_i;
        if (wb_wren_i && (wb_addr_i != 5'd0) && (wb_addr_i == rs2_addr_o))
            op2 = wb_data_i;
        hz = if_valid_i && ex_valid_o && ex_mem_rd_o && (ex_rd_addr_o != 5'd0) &&
             ((rs1_used && (ex_rd_addr_o == rs1_addr_o)) ||
              (rs2_used && (ex_rd_addr_o == rs2_addr_o)));
    end

    assign stall_o = hz && !flush_i;

    // ID/EX pipeline register: bubble on flush, stall or empty IF/ID
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i || stall_o || !if_valid_i) begin
            ex_valid_o     <= 1'b0;
            ex_pc_o        <= 32'd0;
            ex_imm_o       <= 32'd0;
            ex_rs1_data_o  <= 32'd0;
            ex_rs2_data_o  <= 32'd0;
            ex_rs1_addr_o  <= 5'd0;
            ex_rs2_addr_o  <= 5'd0;
            ex_rd_addr_o   <= 5'd0;
            ex_alu_op_o    <= 4'd0;
            ex_alu_a_pc_o  <= 1'b0;
            ex_alu_b_imm_o <= 1'b0;
            ex_funct3_o    <= 3'd0;
            ex_mem_rd_o    <= 1'b0;
            ex_mem_wr_o    <= 1'b0;
            ex_rd_wren_o   <= 1'b0;
            ex_wb_sel_o    <= 2'd0;
            ex_branch_o    <= 1'b0;
            ex_jal_o       <= 1'b0;
            ex_jalr_o      <= 1'b0;
            ex_illegal_o   <= 1'b0;
        end else begin
            ex_valid_o     <= 1'b1;
            ex_pc_o        <= if_pc_i;
            ex_imm_o       <= d_imm;
            ex_rs1_data_o  <= op1;
            ex_rs2_data_o  <= op2;
            ex_rs1_addr_o  <= rs1_addr_o;
            ex_rs2_addr_o  <= rs2_addr_o;
            ex_rd_addr_o   <= rd;
            ex_alu_op_o    <= d_alu_op;
            ex_alu_a_pc_o  <= d_a_pc;
            ex_alu_b_imm_o <= d_b_imm;
            ex_funct3_o    <= funct3;
            ex_mem_rd_o    <= d_mem_rd_q;
            ex_mem_wr_o    <= d_mem_wr_q;
            ex_rd_wren_o   <= d_rd_wren;
            ex_wb_sel_o    <= d_wb_sel;
            ex_branch_o    <= d_branch && !d_illegal;
            ex_jal_o       <= d_jal;
            ex_jalr_o      <= d_jalr && !d_illegal;
            ex_illegal_o   <= d_illegal;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with hand-computed expectations.
module tb_id_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_valid_i;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic        flush_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic        wb_wren_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        stall_o;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o;
    logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
    logic [3:0]  ex_alu_op_o;
    logic        ex_alu_a_pc_o, ex_alu_b_imm_o;
    logic [2:0]  ex_funct3_o;
    logic        ex_mem_rd_o, ex_mem_wr_o, ex_rd_wren_o;
    logic [1:0]  ex_wb_sel_o;
    logic        ex_branch_o, ex_jal_o, ex_jalr_o, ex_illegal_o;

    int n_checks = 0;
    int n_errors = 0;

    id_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
        .flush_i(flush_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .wb_wren_i(wb_wren_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .stall_o(stall_o),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
        .ex_rd_addr_o(ex_rd_addr_o), .ex_alu_op_o(ex_alu_op_o),
        .ex_alu_a_pc_o(ex_alu_a_pc_o), .ex_alu_b_imm_o(ex_alu_b_imm_o),
        .ex_funct3_o(ex_funct3_o), .ex_mem_rd_o(ex_mem_rd_o),
        .ex_mem_wr_o(ex_mem_wr_o), .ex_rd_wren_o(ex_rd_wren_o),
        .ex_wb_sel_o(ex_wb_sel_o), .ex_branch_o(ex_branch_o),
        .ex_jal_o(ex_jal_o), .ex_jalr_o(ex_jalr_o), .ex_illegal_o(ex_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        if_valid_i = 1'b1;
        if_instr_i = instr;
        if_pc_i    = pc;
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".valid"}, ex_valid_o, 0);
        check({tag, ".mem_rd"}, ex_mem_rd_o, 0);
        check({tag, ".rd_wren"}, ex_rd_wren_o, 0);
        check({tag, ".rd_addr"}, ex_rd_addr_o, 0);
        check({tag, ".imm"}, ex_imm_o, 0);
    endtask

    initial begin
        rst_i      = 1'b1;
        if_valid_i = 1'b0;
        if_instr_i = 32'd0;
        if_pc_i    = 32'd0;
        flush_i    = 1'b0;
        rs1_data_i = 32'd0;
        rs2_data_i = 32'd0;
        wb_wren_i  = 1'b0;
        wb_addr_i  = 5'd0;
        wb_data_i  = 32'd0;

        // reset
        repeat (3) tick();
        check_bubble("rst");
        check("rst.pc", ex_pc_o, 0);
        check("rst.alu_op", ex_alu_op_o, 0);
        check("rst.wb_sel", ex_wb_sel_o, 0);
        check("rst.stall", stall_o, 0);

        // addi x1,x0,5
        rst_i = 1'b0;
        present(32'h0050_0093, 32'h0);
        tick();
        check("addi.valid", ex_valid_o, 1);
        check("addi.rd", ex_rd_addr_o, 1);
        check("addi.imm", ex_imm_o, 5);
        check("addi.alu_op", ex_alu_op_o, 0);
        check("addi.b_imm", ex_alu_b_imm_o, 1);
        check("addi.rd_wren", ex_rd_wren_o, 1);

        // lw x2,0(x1) then add x3,x2,x1
        present(32'h0000_A103, 32'h4);
        check("lw.no_stall", stall_o, 0);
        tick();
        check("lw.mem_rd", ex_mem_rd_o, 1);
        check("lw.wb_sel", ex_wb_sel_o, 1);
        check("lw.rd", ex_rd_addr_o, 2);
        check("lw.funct3", ex_funct3_o, 2);
        present(32'h0011_01B3, 32'h8);
        check("lu.stall", stall_o, 1);
        tick();
        check_bubble("lu.bubble");
        check("lu.stall_clear", stall_o, 0);
        tick();
        check("add.valid", ex_valid_o, 1);
        check("add.rs1", ex_rs1_addr_o, 2);
        check("add.rs2", ex_rs2_addr_o, 1);
        check("add.rd", ex_rd_addr_o, 3);
        check("add.b_imm", ex_alu_b_imm_o, 0);
        check("add.pc", ex_pc_o, 32'h8);

        // same hazard with flush
        present(32'h0000_A103, 32'hC);
        tick();
        flush_i = 1'b1;
        present(32'h0011_01B3, 32'h10);
        check("flush.stall", stall_o, 0);
        tick();
        check_bubble("flush.bubble");
        flush_i = 1'b0;

        // bypass: add x6,x5,x0 with WB writing x5
        wb_wren_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEAD_BEEF;
        rs1_data_i = 32'd0; rs2_data_i = 32'h2222_2222;
        present(32'h0002_8333, 32'h14);
        check("byp.rs1_addr", rs1_addr_o, 5);
        tick();
        check("byp.rs1_data", ex_rs1_data_o, 32'hDEAD_BEEF);
        check("byp.rs2_data", ex_rs2_data_o, 32'h2222_2222);
        // WB to x0 is never bypassed
        wb_addr_i = 5'd0;
        present(32'h0000_0333, 32'h18);
        tick();
        check("byp.x0", ex_rs1_data_o, 0);
        // WB to a different register leaves the read data alone
        wb_addr_i = 5'd7; rs1_data_i = 32'h1111_1111;
        present(32'h0002_8333, 32'h1C);
        tick();
        check("byp.other", ex_rs1_data_o, 32'h1111_1111);
        wb_wren_i = 1'b0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;

        // beq x0,x0,-4
        present(32'hFE00_0EE3, 32'h20);
        tick();
        check("beq.imm", ex_imm_o, 32'hFFFF_FFFC);
        check("beq.branch", ex_branch_o, 1);
        check("beq.alu_op", ex_alu_op_o, 1);
        check("beq.rd_wren", ex_rd_wren_o, 0);
        check("beq.b_imm", ex_alu_b_imm_o, 0);

        // lui x1,0x12345
        present(32'h1234_50B7, 32'h24);
        tick();
        check("lui.imm", ex_imm_o, 32'h1234_5000);
        check("lui.alu_op", ex_alu_op_o, 10);
        check("lui.rd_wren", ex_rd_wren_o, 1);
        check("lui.b_imm", ex_alu_b_imm_o, 1);

        // sw x2,4(x1)
        present(32'h0020_A223, 32'h28);
        tick();
        check("sw.imm", ex_imm_o, 4);
        check("sw.mem_wr", ex_mem_wr_o, 1);
        check("sw.rd_wren", ex_rd_wren_o, 0);

        // illegal encodings
        present(32'h4000_1033, 32'h2C);
        tick();
        check("ill1.valid", ex_valid_o, 1);
        check("ill1.illegal", ex_illegal_o, 1);
        check("ill1.rd_wren", ex_rd_wren_o, 0);
        check("ill1.mem_wr", ex_mem_wr_o, 0);
        present(32'hFFFF_FFFF, 32'h30);
        tick();
        check("ill2.illegal", ex_illegal_o, 1);
        check("ill2.rd_wren", ex_rd_wren_o, 0);
        check("ill2.mem_wr", ex_mem_wr_o, 0);
        check("ill2.mem_rd", ex_mem_rd_o, 0);

        // fence is a valid nop
        present(32'h0000_000F, 32'h34);
        tick();
        check("fence.valid", ex_valid_o, 1);
        check("fence.illegal", ex_illegal_o, 0);
        check("fence.rd_wren", ex_rd_wren_o, 0);

        // empty IF/ID gives a bubble
        if_valid_i = 1'b0;
        tick();
        check_bubble("idle");

        // asynchronous reset while ID/EX holds a load
        present(32'h0000_A103, 32'h38);
        tick();
        check("mid.mem_rd", ex_mem_rd_o, 1);
        present(32'h0011_01B3, 32'h3C);
        check("mid.stall_pre", stall_o, 1);
        #1 rst_i = 1'b1;
        #1;
        check("mid.valid", ex_valid_o, 0);
        check("mid.mem_rd_clr", ex_mem_rd_o, 0);
        check("mid.stall", stall_o, 0);
        tick();
        rst_i = 1'b0;
        present(32'h0050_0093, 32'h40);
        tick();
        check("post.valid", ex_valid_o, 1);
        check("post.pc", ex_pc_o, 32'h40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
